// File: rtl/cache_refill_ctrl.sv
// Line-refill controller: on a cache miss, invalidates the target line, streams the
// block in from main memory one word per handshake, then writes the tag back as valid.
module cache_refill_ctrl #(
  parameter int WORDS_PER_LINE = 16,
  parameter int INDEX_W        = 8,
  parameter int TAG_W          = 18
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                miss_valid,
  input  logic [31:0]                         miss_addr,
  output logic                                miss_ready,
  output logic                                mem_req,
  output logic [31:0]                         mem_addr,
  input  logic                                mem_ack,
  input  logic [31:0]                         mem_rdata,
  output logic                                fill_we,
  output logic [INDEX_W-1:0]                  fill_index,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   fill_word,
  output logic [31:0]                         fill_data,
  output logic                                tag_we,
  output logic [TAG_W-1:0]                    tag_data,
  output logic                                tag_valid,
  output logic                                fill_done
);

  localparam int OFF_W    = $clog2(WORDS_PER_LINE);
  localparam int LINE_LSB = OFF_W + 2;
  localparam int LINE_W   = 32 - LINE_LSB;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INVAL = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_TAG   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q,     state_d;
  logic [OFF_W-1:0]   cnt_q,       cnt_d;
  logic [LINE_W-1:0]  line_q,      line_d;
  logic [INDEX_W-1:0] index_q,     index_d;
  logic [TAG_W-1:0]   tag_q,       tag_d;
  logic               fill_we_q,   fill_we_d;
  logic [OFF_W-1:0]   fill_word_q, fill_word_d;
  logic [31:0]        fill_data_q, fill_data_d;

  logic accept;
  logic word_ack;

  // Only the IDLE and REQ states look at their inputs, so acks or misses elsewhere are dropped.
  assign accept   = (state_q == S_IDLE) && miss_valid;
  assign word_ack = (state_q == S_REQ) && mem_ack;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    index_d     = index_q;
    tag_d       = tag_q;
    fill_we_d   = 1'b0;
    fill_word_d = fill_word_q;
    fill_data_d = fill_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          line_d  = miss_addr[31:LINE_LSB];
          index_d = miss_addr[LINE_LSB +: INDEX_W];
          tag_d   = miss_addr[31 -: TAG_W];
          cnt_d   = '0;
          state_d = S_INVAL;
        end
      end
      S_INVAL: state_d = S_REQ;
      S_REQ: begin
        if (word_ack) begin
          fill_we_d   = 1'b1;
          fill_word_d = cnt_q;
          fill_data_d = mem_rdata;
          cnt_d       = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) state_d = S_TAG;
        end
      end
      S_TAG:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      index_q     <= '0;
      tag_q       <= '0;
      fill_we_q   <= 1'b0;
      fill_word_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      fill_we_q   <= fill_we_d;
      fill_word_q <= fill_word_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Address is built by concatenation so the word offset can never carry into the index/tag.
  assign mem_addr   = {line_q, cnt_q, 2'b00};
  assign miss_ready = (state_q == S_IDLE);
  assign mem_req    = (state_q == S_REQ);
  assign tag_we     = (state_q == S_INVAL) || (state_q == S_TAG);
  assign tag_valid  = (state_q == S_TAG);
  assign fill_done  = (state_q == S_DONE);
  assign fill_we    = fill_we_q;
  assign fill_word  = fill_word_q;
  assign fill_data  = fill_data_q;
  assign fill_index = index_q;
  assign tag_data   = tag_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: table of refill scenarios checked cycle by cycle against
// a timeline model derived from the bench's own ack decisions.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [7:0]  fill_index;
  logic [3:0]  fill_word;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [17:0] tag_data;
  logic        tag_valid;
  logic        fill_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    int          mode;      // 0: ack tied high, 1: ack every third cycle, 2: random ack
    bit          keep;      // hold miss_valid high with next_addr during the refill
    logic [31:0] next_addr;
    int          abort_at;  // pulse reset after this many acks (0 = never)
    logic [31:0] base;
    logic [7:0]  idx;
    logic [17:0] tag;
    int          done_cyc;  // expected fill_done cycle, -1 when ack pattern is random
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  assign mem_rdata = memval(mem_addr);

  cache_refill_ctrl #(.WORDS_PER_LINE(16), .INDEX_W(8), .TAG_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_index(fill_index), .fill_word(fill_word), .fill_data(fill_data),
    .tag_we(tag_we), .tag_data(tag_data), .tag_valid(tag_valid), .fill_done(fill_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tagname);
    chk({tagname, ".miss_ready"}, miss_ready, 1);
    chk({tagname, ".mem_req"},    mem_req,    0);
    chk({tagname, ".fill_we"},    fill_we,    0);
    chk({tagname, ".tag_we"},     tag_we,     0);
    chk({tagname, ".tag_valid"},  tag_valid,  0);
    chk({tagname, ".fill_done"},  fill_done,  0);
    chk({tagname, ".mem_addr"},   mem_addr,   0);
    chk({tagname, ".fill_index"}, fill_index, 0);
    chk({tagname, ".fill_word"},  fill_word,  0);
    chk({tagname, ".fill_data"},  fill_data,  0);
    chk({tagname, ".tag_data"},   tag_data,   0);
  endtask

  // Called #1 after a rising edge with the controller idle; returns at the same phase.
  task automatic run_refill(input vec_t v);
    int t, acks, last, wcnt, pend_k;
    bit pend, ack, e_req;
    chk("ready_before_miss", miss_ready, 1);
    miss_valid = 1'b1;
    miss_addr  = v.addr;
    mem_ack    = (v.mode == 0);
    @(posedge clk); #1;
    miss_valid = v.keep;
    miss_addr  = v.keep ? v.next_addr : $urandom;
    acks = 0; last = 100000; wcnt = 0; pend = 1'b0; pend_k = 0;
    for (t = 1; t <= 600; t++) begin
      e_req = (t >= 2) && (acks < 16);
      chk("miss_ready", miss_ready, t >= last + 3);
      chk("mem_req", mem_req, e_req);
      if (e_req) chk("mem_addr", mem_addr, v.base + 32'(acks * 4));
      chk("fill_we", fill_we, pend);
      if (pend) begin
        chk("fill_word", fill_word, pend_k);
        chk("fill_data", fill_data, memval(v.base + 32'(pend_k * 4)));
        chk("fill_index_w", fill_index, v.idx);
      end
      chk("tag_we", tag_we, (t == 1) || (t == last + 1));
      chk("tag_valid", tag_valid, t == last + 1);
      if (t == 1 || t == last + 1) begin
        chk("tag_index", fill_index, v.idx);
        chk("tag_data", tag_data, v.tag);
      end
      chk("fill_done", fill_done, t == last + 2);
      if (v.done_cyc >= 0 && t == v.done_cyc) chk("done_at_cycle", fill_done, 1);
      if (v.done_cyc >= 0 && t == v.done_cyc + 1) chk("ready_at_cycle", miss_ready, 1);
      if (t == last + 3) break;
      if (v.mode == 0)      ack = 1'b1;
      else if (v.mode == 1) ack = e_req && (wcnt == 2);
      else                  ack = ($urandom_range(0, 99) < 55);
      mem_ack = ack;
      pend    = e_req && ack;
      pend_k  = acks;
      if (e_req) begin
        if (ack) begin
          acks++;
          wcnt = 0;
          if (acks == 16) last = t;
        end else begin
          wcnt++;
        end
      end
      if (v.abort_at > 0 && pend && acks == v.abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outs("async_rst");
        repeat (2) begin
          @(posedge clk); #1;
          check_reset_outs("rst_held");
        end
        #2 rst_n = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          chk("post_rst_tag_we", tag_we, 0);
          chk("post_rst_fill_we", fill_we, 0);
          chk("post_rst_ready", miss_ready, 1);
        end
        mem_ack = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (t > 600) chk("refill_timeout", t, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] idle_addr;
    vecs[0] = '{32'h0000_4A44, 0, 1'b0, 32'h0, 0, 32'h0000_4A40, 8'h29, 18'h00001, 19};
    vecs[1] = '{32'h1234_5678, 1, 1'b0, 32'h0, 0, 32'h1234_5640, 8'h59, 18'h048D1, 51};
    vecs[2] = '{32'hABCD_E010, 0, 1'b1, 32'h0000_7F00, 0, 32'hABCD_E000, 8'h80, 18'h2AF37, 19};
    vecs[3] = '{32'h0000_7F00, 0, 1'b0, 32'h0, 0, 32'h0000_7F00, 8'hFC, 18'h00001, 19};
    vecs[4] = '{32'h0000_4A44, 0, 1'b0, 32'h0, 7, 32'h0000_4A40, 8'h29, 18'h00001, -1};
    vecs[5] = '{32'h0000_8884, 0, 1'b0, 32'h0, 0, 32'h0000_8880, 8'h22, 18'h00002, 19};
    vecs[6] = '{32'hFFFF_FFFC, 0, 1'b0, 32'h0, 0, 32'hFFFF_FFC0, 8'hFF, 18'h3FFFF, 19};
    for (int i = 7; i < NV; i++) begin
      a = $urandom;
      vecs[i] = '{a, 2, 1'b0, 32'h0, 0, {a[31:6], 6'b0}, a[13:6], a[31:14], -1};
    end

    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = 32'h0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    rst_n = 1'b1;

    // Spurious acks while idle must not move the counter or write anything.
    mem_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_ack_fill_we", fill_we, 0);
      chk("idle_ack_mem_req", mem_req, 0);
      chk("idle_ack_tag_we", tag_we, 0);
      chk("idle_ack_mem_addr", mem_addr, 0);
    end

    for (int i = 0; i < NV; i++) run_refill(vecs[i]);

    miss_valid = 1'b0;
    mem_ack = 1'b1;
    idle_addr = mem_addr;
    repeat (3) begin
      @(posedge clk); #1;
      chk("final_idle_mem_addr", mem_addr, idle_addr);
      chk("final_idle_fill_we", fill_we, 0);
      chk("final_idle_ready", miss_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Line-refill controller sitting directly downstream of the direct-mapped cache's miss output. On a miss it accepts the 32-bit miss address, invalidates the target line, fetches the full 16-word block from main memory one word per request/acknowledge handshake, and writes each word into the cache data array. It then writes the new tag with its valid bit set and pulses `fill_done` so the cache can replay the access.

## Interface
- `WORDS_PER_LINE`, 16, words per cache line; power of two. Word offset is `Address[5:2]`.
- `INDEX_W`, 8, index width; index is `Address[13:6]`.
- `TAG_W`, 18, tag width; tag is `Address[31:14]`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `miss_valid`  in  1  cache reports a miss on `miss_addr`.
- `miss_addr`  in  32  byte address of the missing access.
- `miss_ready`  out  1  controller idle and able to accept a miss.
- `mem_req`  out  1  word read request to main memory.
- `mem_addr`  out  32  word-aligned read address.
- `mem_ack`  in  1  memory accepts the request; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.
- `fill_we`  out  1  write one word into the data array.
- `fill_index`  out  INDEX_W  line index for data and tag writes.
- `fill_word`  out  4  word slot within the line.
- `fill_data`  out  32  word to write.
- `tag_we`  out  1  write the tag array entry at `fill_index`.
- `tag_data`  out  TAG_W  tag to write.
- `tag_valid`  out  1  valid bit written with the tag.
- `fill_done`  out  1  one-cycle pulse when the line is complete.

## Operation
- States: IDLE, INVAL, REQ, TAG, DONE.
- **IDLE**
  - `miss_ready=1`.
  - On `miss_valid && miss_ready`, latch:
    - `base = {miss_addr[31:6], 6'b0}`
    - `fill_index = miss_addr[13:6]`
    - `tag_data = miss_addr[31:14]`
  - Clear word counter `cnt` (4 bits). Go to INVAL.
- **INVAL**
  - One cycle, `tag_we=1`, `tag_valid=0`, `tag_data` = latched tag.
  - Go to REQ.
- **REQ**
  - `mem_req=1`, `mem_addr = base + {cnt, 2'b00}`.
  - `mem_addr` is held stable until `mem_ack`.
  - On `mem_ack`, register `fill_data<=mem_rdata`, `fill_word<=cnt` and `fill_we<=1` for exactly one cycle, then `cnt<=cnt+1`.
  - Back-to-back acks are legal: the next address is presented the cycle after an ack.
  - The ack at `cnt==15` moves to TAG. The 4-bit counter wraps to 0 and is not used again.
- **TAG**
  - One cycle, `tag_we=1`, `tag_valid=1`.
  - The last word's `fill_we` is concurrent with this cycle, which is legal because the arrays are separate.
  - Go to DONE.
- **DONE**
  - One cycle, `fill_done=1`. Go to IDLE.
- `mem_ack` while `mem_req=0` is ignored.
- `miss_valid` while `miss_ready=0` is ignored; upstream holds it until accepted.
- `miss_addr` is sampled only on acceptance; later changes have no effect on the refill in progress.

## Timing
- Reset values: state IDLE, `cnt=0`.
  - `miss_ready=1`.
  - `mem_req`, `fill_we`, `tag_we`, `tag_valid`, `fill_done` all 0.
  - `mem_addr`, `fill_index`, `fill_word`, `fill_data`, `tag_data` all 0.
- `mem_req`, `tag_we`, `tag_valid`, `fill_done` and `miss_ready` decode from the state register; no combinational path from inputs.
- `fill_we` is registered and lags its `mem_ack` by one cycle.
- Minimum latency with `mem_ack` tied high, accept at cycle 0:
  - INVAL at cycle 1.
  - REQ cycles 2–17.
  - `fill_we` cycles 3–18.
  - TAG at cycle 18.
  - `fill_done` at cycle 19.
  - `miss_ready=1` again at cycle 20.
- Each wait cycle without `mem_ack` adds exactly one cycle.
- Reset asserted mid-refill: immediate return to reset values. No further `fill_we` or `tag_we`. A line already invalidated stays invalid, so the cache cannot hit on partial data.

## Test plan
- Reset, then miss at `0x0000_4A44` with `mem_ack` tied high:
  - Cycle 1: `tag_we=1`, `tag_valid=0`, `fill_index=0x29`, `tag_data=0x00001`.
  - `mem_addr` steps `0x4A40` through `0x4A7C` over cycles 2–17.
  - `fill_word` runs 0..15 over cycles 3–18, with `fill_data` equal to the memory model contents.
  - Cycle 18: `tag_valid=1`. Cycle 19: `fill_done`. Cycle 20: `miss_ready=1`.
- Memory model acks every third cycle: `mem_addr` stays stable between acks, exactly 16 `fill_we` pulses occur, and `fill_done` arrives at cycle 51.
- `miss_valid` held high with a different address during a refill: no second acceptance until `miss_ready` returns. The second line then refills with its own index and tag.
- Spurious `mem_ack` pulses in IDLE, INVAL and TAG: no `fill_we` and no counter change.
- `rst_n` pulsed low after the 7th ack:
  - All outputs return to reset values asynchronously.
  - No `tag_we` with `tag_valid=1` ever occurs for that line.
  - The next miss refills correctly.
- Miss at `0xFFFF_FFFC`:
  - `base=0xFFFF_FFC0`, `fill_index=0xFF`, `tag_data=0x3FFFF`.
  - Last `mem_addr=0xFFFF_FFFC` with no overflow into other fields.
